alu_arbitro: RTL
================

Name: alu_arbitro

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 32-bit combinational ALU.
- Accepts operand/opcode requests over a valid/ready handshake and drives the ALU from registered operands.
- Captures the result and zero flag, then returns them on a single tagged response channel with backpressure.
- Sits between the two datapath clients and the single ALU instance.

Parameters:
- ANCHO, 32, operand/result width.
- OP_W, 4, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  2  bit i = requester i presents a request.
- req_ready  out  2  bit i = request i accepted this cycle.
- req0_a, req0_b  in  ANCHO  requester 0 operands.
- req0_op  in  OP_W  requester 0 opcode.
- req1_a, req1_b  in  ANCHO  requester 1 operands.
- req1_op  in  OP_W  requester 1 opcode.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_id  out  1  requester the response belongs to.
- resp_dato  out  ANCHO  ALU result.
- resp_zf  out  1  ALU zero flag.
- alu_datoIn1, alu_datoIn2  out  ANCHO  operands to the ALU.
- alu_op  out  OP_W  opcode to the ALU.
- alu_datoOut  in  ANCHO  ALU result.
- alu_zf  in  1  ALU zero flag.

Behaviour:
- Clock and reset: single clock domain `clk`. `rst` is asynchronous and active-high. All state and registered outputs clear immediately on `rst`.
- Reset values:
  - State = IDLE, priority pointer = 0.
  - Operand, opcode and id registers = 0, so alu_datoIn1/alu_datoIn2/alu_op = 0.
  - resp_valid = 0, resp_id = 0, resp_dato = 0, resp_zf = 0, req_ready = 2'b00.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from req_valid and the pointer.
  - Only one valid: grant it regardless of the pointer.
  - Both valid: grant the requester the pointer selects.
  - req_ready[g] = 1 for the granted requester only. req_ready is 0 in every other state.
  - On the accept edge, latch a/b/op of the granted requester and id = g.
  - Set pointer = ~g. Next state EXEC.
  - No valid: stay in IDLE, req_ready = 0.
- EXEC:
  - alu_* are driven from the latched registers. They are always driven from the registers and change only on accept.
  - On the edge, capture alu_datoOut into resp_dato and alu_zf into resp_zf. Next state RESP.
- RESP:
  - resp_valid = 1. resp_dato, resp_zf and resp_id stay stable while resp_ready = 0.
  - On an edge with resp_ready = 1: resp_valid goes to 0 and the state returns to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Latency and throughput:
  - Accept at edge N → resp_valid high from cycle N+2.
  - Maximum throughput is one operation per 3 cycles when resp_ready is held at 1.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Requests that are not granted must be held by the requester; the arbiter never drops them.
- Reset mid-operation: an in-flight transaction is discarded and no response is produced. After release, a pending req_valid[0] wins a tie.
- Opcodes are passed through unchanged. Undefined opcodes return whatever the ALU produces, which is 0 with zf = 1.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- When defined:
  - Add output resp_err (1 bit, reset 0).
  - In EXEC, an opcode outside {0000, 0001, 0010, 0110, 0111, 1100} sets resp_err = 1, resp_dato = 0, resp_zf = 0. ALU outputs are ignored for that transaction.
  - Legal opcodes give resp_err = 0.
  - Timing is unchanged.
- When undefined: no resp_err port, and no opcode decode logic.

Test Plan:
- Single add: req_valid = 01, req0 = (5, 7, 0010), resp_ready = 1 → req_ready = 01 for 1 cycle; 2 cycles later resp_valid = 1, resp_id = 0, resp_dato = 12, resp_zf = 0.
- Tie after reset: both valid, req0 = (9, 9, 0110), req1 = (3, 4, 0001) → first response id 0, dato 0, zf 1; second response id 1, dato 7, zf 0.
- Fairness: both valid continuously for 4 transactions, resp_ready = 1 → ids 0, 1, 0, 1; one response every 3 cycles.
- Backpressure: resp_ready = 0 for 4 cycles during RESP with req1 = (2, 3, 0111) → resp_valid, dato 1 and id 1 held stable; req_ready = 00 throughout; completes on the cycle after resp_ready rises.
- Reset mid-EXEC: assert rst asynchronously during EXEC → resp_valid = 0 immediately, state IDLE, no response for that request; pointer = 0.
- With ALU_ARB_OPCHECK_EN: req0 = (1, 1, 0011) → resp_err = 1, resp_dato = 0, resp_zf = 0; then (1, 1, 0010) → resp_err = 0, dato 2.

Source files
------------

// File: rtl/alu_arbitro.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Optional opcode legality check (adds resp_err) enabled with `define ALU_ARB_OPCHECK_EN.
module alu_arbitro #(
    parameter int unsigned ANCHO = 32,
    parameter int unsigned OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [ANCHO-1:0] req0_a,
    input  logic [ANCHO-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [ANCHO-1:0] req1_a,
    input  logic [ANCHO-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [ANCHO-1:0] resp_dato,
    output logic             resp_zf,
    output logic [ANCHO-1:0] alu_datoIn1,
    output logic [ANCHO-1:0] alu_datoIn2,
    output logic [OP_W-1:0]  alu_op,
    input  logic [ANCHO-1:0] alu_datoOut,
    input  logic             alu_zf
`ifdef ALU_ARB_OPCHECK_EN
    ,
    output logic             resp_err
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [ANCHO-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             id_q, id_d;
    logic [ANCHO-1:0] dato_q, dato_d;
    logic             zf_q, zf_d;
    logic             valid_q, valid_d;
    logic [1:0]       ready_c;
    logic             gnt_c;
`ifdef ALU_ARB_OPCHECK_EN
    logic             err_q, err_d;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_W'(0), OP_W'(1), OP_W'(2), OP_W'(6), OP_W'(7), OP_W'(12): op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    endfunction
`endif

    // Single requester wins outright; a tie goes to the pointer.
    assign gnt_c = (req_valid == 2'b11) ? ptr_q : req_valid[1];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        dato_d  = dato_q;
        zf_d    = zf_q;
        valid_d = valid_q;
        ready_c = 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    ready_c = gnt_c ? 2'b10 : 2'b01;
                    a_d     = gnt_c ? req1_a  : req0_a;
                    b_d     = gnt_c ? req1_b  : req0_b;
                    op_d    = gnt_c ? req1_op : req0_op;
                    id_d    = gnt_c;
                    ptr_d   = ~gnt_c;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                dato_d  = alu_datoOut;
                zf_d    = alu_zf;
                valid_d = 1'b1;
                state_d = RESP;
`ifdef ALU_ARB_OPCHECK_EN
                err_d   = ~op_legal(op_q);
                if (!op_legal(op_q)) begin
                    dato_d = '0;
                    zf_d   = 1'b0;
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            dato_q  <= '0;
            zf_q    <= 1'b0;
            valid_q <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            dato_q  <= dato_d;
            zf_q    <= zf_d;
            valid_q <= valid_d;
`ifdef ALU_ARB_OPCHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Grant is combinational but must read as idle while reset is held.
    assign req_ready   = ready_c & {2{~rst}};
    assign resp_valid  = valid_q;
    assign resp_id     = id_q;
    assign resp_dato   = dato_q;
    assign resp_zf     = zf_q;
    assign alu_datoIn1 = a_q;
    assign alu_datoIn2 = b_q;
    assign alu_op      = op_q;
`ifdef ALU_ARB_OPCHECK_EN
    assign resp_err    = err_q;
`endif

endmodule
